mem_port_arb: RTL and testbench



---
 rtl/mem_port_arb_pkg.sv | 13 +
 rtl/mem_tag_fifo.sv | 81 ++++++++
 rtl/mem_port_arb.sv | 134 +++++++++++++
 tb/tb_mem_port_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// rtl/mem_port_arb_pkg.sv - shared types for the memory port arbiter
//
// Purpose: source tag encoding shared by the arbiter top and its tag FIFO.
//   SRC_FCH (0) marks an instruction-fetch request.
//   SRC_LSU (1) marks a load/store request.
package mem_port_arb_pkg;

  typedef enum logic {
    SRC_FCH = 1'b0,
    SRC_LSU = 1'b1
  } mem_src_e;

endpackage

// File: rtl/mem_tag_fifo.sv
// rtl/mem_tag_fifo.sv - in-order source-tag FIFO for outstanding memory requests
//
// Purpose: remembers which requester issued each accepted memory request, so
// in-order responses can be steered back to it.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (discards all tags)
//   push_i     - store tag_i at the tail (ignored while full)
//   tag_i      - source tag (0 = fetch, 1 = LSU)
//   pop_i      - drop the head entry (ignored while empty)
//   full_o     - DEPTH entries held
//   empty_o    - no entries held
//   head_o     - tag of the oldest entry
module mem_tag_fifo
  import mem_port_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic tag_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  // A depth of 1 still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = tag_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      tag_d[wr_ptr_q] = tag_i;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - fetch/LSU arbiter and response router for the single memory port
//
// Purpose: picks one of the fetch and LSU requests per cycle, passes it to
// memory combinationally, records its source in an in-order tag FIFO, and
// steers each in-order memory response back to the requester that issued it.
// Optional feature: define MEM_PORT_ARB_RR_EN for round-robin arbitration on
// ties; otherwise LSU has fixed priority over fetch.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   f_req_* / f_rsp_*        - fetch request (addr) and response (data)
//   l_req_* / l_rsp_*        - LSU request (addr, we, wdata, wstrb) and response/write ack
//   m_req_* / m_rsp_*        - memory request and in-order memory response
//   busy                     - at least one request awaits its response
//   err                      - sticky: a response arrived with nothing outstanding
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTSTD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req_vld,
  output logic                f_req_rdy,
  input  logic [ADDR_W-1:0]   f_req_addr,
  output logic                f_rsp_vld,
  input  logic                f_rsp_rdy,
  output logic [DATA_W-1:0]   f_rsp_data,
  input  logic                l_req_vld,
  output logic                l_req_rdy,
  input  logic [ADDR_W-1:0]   l_req_addr,
  input  logic                l_req_we,
  input  logic [DATA_W-1:0]   l_req_wdata,
  input  logic [DATA_W/8-1:0] l_req_wstrb,
  output logic                l_rsp_vld,
  input  logic                l_rsp_rdy,
  output logic [DATA_W-1:0]   l_rsp_data,
  output logic                m_req_vld,
  input  logic                m_req_rdy,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_we,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  input  logic                m_rsp_vld,
  output logic                m_rsp_rdy,
  input  logic [DATA_W-1:0]   m_rsp_data,
  output logic                busy,
  output logic                err
);

  mem_src_e win;
  logic     win_lsu;
  logic     fifo_full, fifo_empty, head_lsu;
  logic     push, pop;
  logic     err_q, err_d;

`ifdef MEM_PORT_ARB_RR_EN
  mem_src_e last_gnt_q, last_gnt_d;
`endif

  // Winner selection; only meaningful while at least one requester is valid.
  always_comb begin
    win = SRC_FCH;
`ifdef MEM_PORT_ARB_RR_EN
    if (f_req_vld && l_req_vld) begin
      win = (last_gnt_q == SRC_FCH) ? SRC_LSU : SRC_FCH;
    end else if (l_req_vld) begin
      win = SRC_LSU;
    end
`else
    if (l_req_vld) begin
      win = SRC_LSU;
    end
`endif
  end

  assign win_lsu = (win == SRC_LSU);

  // Request path: full FIFO blocks every grant so no tag can be lost.
  assign m_req_vld   = (f_req_vld | l_req_vld) & ~fifo_full;
  assign m_req_addr  = win_lsu ? l_req_addr : f_req_addr;
  assign m_req_we    = win_lsu & l_req_we;
  assign m_req_wdata = win_lsu ? l_req_wdata : '0;
  assign m_req_wstrb = win_lsu ? l_req_wstrb : '0;
  assign f_req_rdy   = f_req_vld & ~win_lsu & m_req_rdy & ~fifo_full;
  assign l_req_rdy   = l_req_vld & win_lsu & m_req_rdy & ~fifo_full;
  assign push        = m_req_vld & m_req_rdy;

  // Response path: the FIFO head names the owner of the current beat. With
  // nothing outstanding the beat is accepted and dropped so memory never stalls.
  assign f_rsp_vld  = m_rsp_vld & ~fifo_empty & ~head_lsu;
  assign l_rsp_vld  = m_rsp_vld & ~fifo_empty & head_lsu;
  assign m_rsp_rdy  = fifo_empty ? m_rsp_vld : (head_lsu ? l_rsp_rdy : f_rsp_rdy);
  assign f_rsp_data = m_rsp_data;
  assign l_rsp_data = m_rsp_data;
  assign pop        = m_rsp_vld & m_rsp_rdy & ~fifo_empty;

  assign busy  = ~fifo_empty;
  assign err   = err_q;
  assign err_d = err_q | (m_rsp_vld & fifo_empty);

`ifdef MEM_PORT_ARB_RR_EN
  assign last_gnt_d = push ? win : last_gnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      last_gnt_q <= SRC_LSU;
`endif
    end else begin
      err_q      <= err_d;
`ifdef MEM_PORT_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  mem_tag_fifo #(
    .DEPTH(OUTSTD)
  ) u_tag_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .tag_i  (win_lsu),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head_lsu)
  );

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - randomized scoreboard bench for mem_port_arb
module tb_mem_port_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OUTSTD = 2;
  localparam int N_F    = 120;
  localparam int N_L    = 120;
  localparam logic [31:0] FBASE = 32'h0000_0100;
  localparam logic [31:0] LBASE = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req_vld, f_req_rdy, f_rsp_vld, f_rsp_rdy;
  logic [31:0] f_req_addr, f_rsp_data;
  logic        l_req_vld, l_req_rdy, l_req_we, l_rsp_vld, l_rsp_rdy;
  logic [31:0] l_req_addr, l_req_wdata, l_rsp_data;
  logic [3:0]  l_req_wstrb;
  logic        m_req_vld, m_req_rdy, m_req_we, m_rsp_vld, m_rsp_rdy;
  logic [31:0] m_req_addr, m_req_wdata, m_rsp_data;
  logic [3:0]  m_req_wstrb;
  logic        busy, err;

  always #5 clk = ~clk;

  mem_port_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTD(OUTSTD)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req_vld(f_req_vld), .f_req_rdy(f_req_rdy), .f_req_addr(f_req_addr),
    .f_rsp_vld(f_rsp_vld), .f_rsp_rdy(f_rsp_rdy), .f_rsp_data(f_rsp_data),
    .l_req_vld(l_req_vld), .l_req_rdy(l_req_rdy), .l_req_addr(l_req_addr),
    .l_req_we(l_req_we), .l_req_wdata(l_req_wdata), .l_req_wstrb(l_req_wstrb),
    .l_rsp_vld(l_rsp_vld), .l_rsp_rdy(l_rsp_rdy), .l_rsp_data(l_rsp_data),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_data(m_rsp_data),
    .busy(busy), .err(err)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic        chk_en  = 1'b0;
  logic        mem_en  = 1'b1;
  logic        started = 1'b0;
  logic        f_done  = 1'b0;
  logic        l_done  = 1'b0;
  logic        tb_last = 1'b1;
  logic [31:0] f_exp_q[$];
  logic [31:0] l_exp_q[$];
  logic [31:0] mrsp_q[$];
  logic        src_q[$];
  logic [31:0] lref[logic [31:0]];
  logic [31:0] mstore[logic [31:0]];

  task automatic check_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] lsu_init(input logic [31:0] a);
    return a * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Fetch requester: read-only region, expected data known at issue time.
  initial begin : fetch_drv
    f_req_vld  = 1'b0;
    f_req_addr = '0;
    wait (started);
    for (int i = 0; i < N_F; i++) begin
      int gap;
      int t;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      f_req_addr = FBASE + (32'($urandom_range(0, 63)) << 2);
      f_req_vld  = 1'b1;
      f_exp_q.push_back(fetch_word(f_req_addr));
      t = 0;
      forever begin
        @(negedge clk);
        if (f_req_rdy) break;
        t++;
        if (t > 5000) begin check_b("f_req_timeout", 1'b0, 1'b1); break; end
      end
      @(posedge clk); #1;
      f_req_vld = 1'b0;
    end
    f_done = 1'b1;
  end

  // LSU requester: small address window so reads observe earlier writes.
  initial begin : lsu_drv
    l_req_vld   = 1'b0;
    l_req_addr  = '0;
    l_req_we    = 1'b0;
    l_req_wdata = '0;
    l_req_wstrb = '0;
    wait (started);
    for (int i = 0; i < N_L; i++) begin
      int gap;
      int t;
      logic [31:0] old;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      l_req_addr  = LBASE + (32'($urandom_range(0, 7)) << 2);
      l_req_we    = 1'($urandom_range(0, 1));
      l_req_wdata = $urandom;
      l_req_wstrb = 4'($urandom_range(0, 15));
      l_req_vld   = 1'b1;
      old = lref.exists(l_req_addr) ? lref[l_req_addr] : lsu_init(l_req_addr);
      if (l_req_we) old = merge(old, l_req_wdata, l_req_wstrb);
      lref[l_req_addr] = old;
      l_exp_q.push_back(old);
      t = 0;
      forever begin
        @(negedge clk);
        if (l_req_rdy) break;
        t++;
        if (t > 5000) begin check_b("l_req_timeout", 1'b0, 1'b1); break; end
      end
      @(posedge clk); #1;
      l_req_vld = 1'b0;
    end
    l_done = 1'b1;
  end

  // Memory slave: random request backpressure, random in-order response delay.
  initial begin : mem_model
    logic [31:0] a;
    logic [31:0] old;
    logic        popd;
    m_req_rdy  = 1'b0;
    m_rsp_vld  = 1'b0;
    m_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (m_req_vld && m_req_rdy) begin
        a = m_req_addr;
        if (a >= LBASE) begin
          old = mstore.exists(a) ? mstore[a] : lsu_init(a);
          if (m_req_we) old = merge(old, m_req_wdata, m_req_wstrb);
          mstore[a] = old;
          mrsp_q.push_back(old);
        end else begin
          mrsp_q.push_back(fetch_word(a));
        end
      end
      popd = m_rsp_vld && m_rsp_rdy;
      @(posedge clk); #1;
      if (mem_en) begin
        if (popd) begin
          void'(mrsp_q.pop_front());
          m_rsp_vld = 1'b0;
        end
        if (!m_rsp_vld && mrsp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          m_rsp_vld  = 1'b1;
          m_rsp_data = mrsp_q[0];
        end
        m_req_rdy = ($urandom_range(0, 4) != 0);
      end
    end
  end

  initial begin : rsp_rdy_drv
    f_rsp_rdy = 1'b0;
    l_rsp_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      f_rsp_rdy = ($urandom_range(0, 3) != 0);
      l_rsp_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: reference model of outstanding sources, arbitration and routing.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic exp_win, exp_mvld, exp_hs, has_head, head, exp_pop;
        has_head = (src_q.size() > 0);
        head     = has_head ? src_q[0] : 1'b0;
        exp_mvld = (f_req_vld || l_req_vld) && (src_q.size() < OUTSTD);
        if (f_req_vld && l_req_vld) begin
`ifdef MEM_PORT_ARB_RR_EN
          exp_win = ~tb_last;
`else
          exp_win = 1'b1;
`endif
        end else begin
          exp_win = l_req_vld;
        end
        exp_hs = exp_mvld && m_req_rdy;

        check_b("busy", busy, has_head);
        check_b("err_clear", err, 1'b0);
        check_b("m_req_vld", m_req_vld, exp_mvld);
        check_w("req_rdy", 32'({f_req_rdy, l_req_rdy}),
                exp_hs ? (exp_win ? 32'd1 : 32'd2) : 32'd0);
        if (exp_mvld) begin
          check_w("m_req_addr", m_req_addr, exp_win ? l_req_addr : f_req_addr);
          check_b("m_req_we", m_req_we, exp_win & l_req_we);
          check_w("m_req_wstrb", 32'(m_req_wstrb), exp_win ? 32'(l_req_wstrb) : 32'd0);
          if (exp_win) check_w("m_req_wdata", m_req_wdata, l_req_wdata);
        end

        check_b("f_rsp_vld", f_rsp_vld, m_rsp_vld && has_head && !head);
        check_b("l_rsp_vld", l_rsp_vld, m_rsp_vld && has_head && head);
        check_b("m_rsp_rdy", m_rsp_rdy,
                has_head ? (head ? l_rsp_rdy : f_rsp_rdy) : m_rsp_vld);
        exp_pop = m_rsp_vld && has_head && (head ? l_rsp_rdy : f_rsp_rdy);

        if (f_rsp_vld && f_rsp_rdy) begin
          if (f_exp_q.size() == 0) check_b("f_rsp_unexpected", 1'b1, 1'b0);
          else check_w("f_rsp_data", f_rsp_data, f_exp_q.pop_front());
        end
        if (l_rsp_vld && l_rsp_rdy) begin
          if (l_exp_q.size() == 0) check_b("l_rsp_unexpected", 1'b1, 1'b0);
          else check_w("l_rsp_data", l_rsp_data, l_exp_q.pop_front());
        end

        if (exp_pop) void'(src_q.pop_front());
        if (exp_hs) begin
          src_q.push_back(exp_win);
          tb_last = exp_win;
        end
      end
    end
  end

  initial begin : main
    int t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_err", err, 1'b0);
    check_b("rst_m_req_vld", m_req_vld, 1'b0);
    check_b("rst_f_req_rdy", f_req_rdy, 1'b0);
    check_b("rst_l_req_rdy", l_req_rdy, 1'b0);
    check_b("rst_f_rsp_vld", f_rsp_vld, 1'b0);
    check_b("rst_l_rsp_vld", l_rsp_vld, 1'b0);
    check_b("rst_m_rsp_rdy", m_rsp_rdy, 1'b0);

    @(posedge clk); #1;
    chk_en  = 1'b1;
    started = 1'b1;
    t = 0;
    forever begin
      @(posedge clk); #2;
      if (f_done && l_done && src_q.size() == 0 && mrsp_q.size() == 0 && !m_rsp_vld) break;
      t++;
      if (t >= 30000) break;
    end
    check_b("drain_in_time", (t < 30000), 1'b1);
    chk_en = 1'b0;
    mem_en = 1'b0;
    check_w("f_rsp_all_delivered", 32'(f_exp_q.size()), 32'd0);
    check_w("l_rsp_all_delivered", 32'(l_exp_q.size()), 32'd0);

    // Orphan response with nothing outstanding.
    @(posedge clk); #1;
    m_rsp_vld  = 1'b1;
    m_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check_b("orphan_m_rsp_rdy", m_rsp_rdy, 1'b1);
    check_b("orphan_f_rsp_vld", f_rsp_vld, 1'b0);
    check_b("orphan_l_rsp_vld", l_rsp_vld, 1'b0);
    check_b("orphan_err_before", err, 1'b0);
    check_b("orphan_busy", busy, 1'b0);
    @(posedge clk); #1;
    m_rsp_vld = 1'b0;
    @(negedge clk);
    check_b("orphan_err_set", err, 1'b1);
    check_b("orphan_m_rsp_rdy_idle", m_rsp_rdy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_b("orphan_err_sticky", err, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_b("err_cleared_by_rst", err, 1'b0);
    check_b("busy_after_rst", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
